encoder_4to2_serial: RTL and testbench
======================================

// Module: encoder_4to2_serial
// PURPOSE
//  Inverse of the 2-to-4 decoder. Accepts a 4-bit request vector (any number
//  of bits set) over a valid/ready handshake and serialises it into a stream
//  of 2-bit binary codes, one per set bit, on a second valid/ready handshake.
//  Sits between request-collection logic and downstream code consumers.
//  Also reports empty (all-zero) vectors and counts the codes it has emitted.
// PARAMETERS
//  CNT_W   8   width of evt_cnt; the counter wraps modulo 2^CNT_W
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      in_vec is valid this cycle
//  in_ready   out  1      block can accept a vector (state IDLE)
//  in_vec     in   4      request vector; bit i requests code i
//  out_valid  out  1      out_code is valid
//  out_ready  in   1      downstream consumes out_code this cycle
//  out_code   out  2      binary index of the selected pending bit
//  out_last   out  1      out_code is the final code of the current vector
//  zero_pulse out  1      one-cycle pulse: an all-zero vector was accepted
//  evt_cnt    out  CNT_W  number of codes consumed (out_valid & out_ready)
// BEHAVIOUR
//  - Reset (sync, rst=1 at an edge):
//    - state=IDLE, pend=0, zero_pulse=0, evt_cnt=0, RR pointer=3.
//    - Resulting outputs: in_ready=1, out_valid=0, out_code=0, out_last=0.
//    - Mid-operation reset discards all pending bits.
//  - FSM has two states, IDLE and EMIT.
//    - in_ready = (state==IDLE).
//    - out_valid = (state==EMIT).
//  - IDLE: accept on in_valid & in_ready.
//    - in_vec!=0: pend<=in_vec, go to EMIT.
//    - in_vec==0: stay in IDLE; zero_pulse=1 for the following cycle only.
//    - in_vec is ignored when not accepted.
//  - EMIT: out_code = selected set bit of pend.
//    - out_last = 1 when pend has exactly one bit set.
//    - On out_valid & out_ready: clear the selected bit and evt_cnt++.
//    - If out_last, go to IDLE.
//  - Timing:
//    - A vector accepted at edge N gives out_valid=1 from cycle N+1.
//    - A vector with k set bits occupies 1+k cycles minimum.
//    - No overlap: in_ready stays low throughout EMIT.
//  - Backpressure: while out_valid & !out_ready, out_code, out_last and pend
//    hold stable.
//  - out_* are derived only from state/pend/pointer registers, with no
//    combinational path from in_* or out_ready.
//  - evt_cnt wraps from 2^CNT_W-1 to 0 with no saturation.
//  - rst has priority over every simultaneous handshake.
// CONFIGURATION
//  ENC_RR_PRIORITY_EN defined:
//    - A 2-bit pointer holds the last emitted code.
//    - Selection scans pend from bit (ptr+1) mod 4 upward, wrapping.
//    - ptr<=out_code on each consume. It persists across vectors; reset value 3.
//  ENC_RR_PRIORITY_EN undefined:
//    - Fixed priority: lowest set index first.
//    - No pointer register.
// TESTING
//  1. in_vec=1010, out_ready=1 -> codes 1 then 3; out_last=1 on 3; evt_cnt=2;
//     in_ready=1 the cycle after the last consume.
//  2. in_vec=0000 accepted -> out_valid stays 0; zero_pulse=1 for exactly one
//     cycle; evt_cnt unchanged; in_ready stays 1.
//  3. in_vec=1111 with out_ready=0 for 3 cycles -> out_code=0 and out_last=0
//     held stable; then codes 0,1,2,3; in_ready=0 until the last consume.
//  4. rst=1 after the first consume of 1111 -> next cycle out_valid=0,
//     in_ready=1, evt_cnt=0, pend=0; the next vector 0100 gives code 2.
//  5. CNT_W=2, five vectors 0001 consumed -> evt_cnt sequence 1,2,3,0,1.
//  6. Vector 0010 then vector 0101:
//     - RR build: codes 1, then 2, 0.
//     - Non-RR build: codes 1, then 0, 2.

Source files
------------

// File: rtl/encoder_4to2_serial.sv
// Serialises a 4-bit request vector into one 2-bit code per set bit; first code valid the cycle after accept.
// Holds code/last/pending bits under out_ready backpressure; define ENC_RR_PRIORITY_EN for round-robin selection.
module encoder_4to2_serial #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_code,
    output logic             out_last,
    output logic             zero_pulse,
    output logic [CNT_W-1:0] evt_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] pend;
    logic [1:0] sel;
    logic       single;
    logic       fire_in;
    logic       fire_out;

    // Exactly one pending bit means the current code closes the vector.
    assign single   = (pend != 4'd0) && ((pend & (pend - 4'd1)) == 4'd0);
    assign fire_in  = in_ready & in_valid;
    assign fire_out = out_valid & out_ready;
    assign out_code = out_valid ? sel : 2'd0;
    assign out_last = out_valid & single;

`ifdef ENC_RR_PRIORITY_EN
    logic [1:0] ptr;
    logic [1:0] idx;
    logic       found;

    // Scan starts just after the last emitted code and wraps around.
    always_comb begin
        sel   = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && pend[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd3;
        end else if (fire_out) begin
            ptr <= sel;
        end
    end
`else
    always_comb begin
        sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pend[i]) begin
                sel = 2'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && (in_vec != 4'd0)) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready && single) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= 4'd0;
            zero_pulse <= 1'b0;
            evt_cnt    <= '0;
        end else begin
            zero_pulse <= fire_in && (in_vec == 4'd0);
            if (fire_in) begin
                pend <= in_vec;
            end else if (fire_out) begin
                pend    <= pend & ~(4'd1 << sel);
                evt_cnt <= evt_cnt + CNT_W'(1);
            end
        end
    end

    // Under backpressure the presented code must not change.
    a_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(out_code) && $stable(out_last) && $stable(pend)));

    a_excl: assert property (@(posedge clk) disable iff (rst) !(in_ready && out_valid));

endmodule

// File: tb/tb_encoder_4to2_serial.sv
// Bench for encoder_4to2_serial: directed vector table, hand sequences and randomized model comparison.
module tb_encoder_4to2_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_vec;
    logic       out_ready;
    logic       in_ready, out_valid, out_last, zero_pulse;
    logic [1:0] out_code;
    logic [7:0] evt_cnt;

    logic       d2_in_ready, d2_out_valid, d2_out_last, d2_zero_pulse;
    logic [1:0] d2_out_code;
    logic [1:0] d2_evt_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    encoder_4to2_serial #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_last(out_last),
        .zero_pulse(zero_pulse), .evt_cnt(evt_cnt)
    );

    encoder_4to2_serial #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready), .in_vec(in_vec),
        .out_valid(d2_out_valid), .out_ready(out_ready), .out_code(d2_out_code), .out_last(d2_out_last),
        .zero_pulse(d2_zero_pulse), .evt_cnt(d2_evt_cnt)
    );

    // Reference model: a queue of the codes still owed for the current vector.
    int q[$];
    bit m_zero;
    int m_cnt;
`ifdef ENC_RR_PRIORITY_EN
    int m_ptr;
`endif

    function automatic void model_step(input bit r, input bit iv, input logic [3:0] v, input bit ordy);
        bit z;
        if (r) begin
            q.delete();
            m_zero = 1'b0;
            m_cnt  = 0;
`ifdef ENC_RR_PRIORITY_EN
            m_ptr  = 3;
`endif
            return;
        end
        z = (q.size() == 0) && iv && (v == 4'd0);
        if (q.size() != 0) begin
            if (ordy) begin
`ifdef ENC_RR_PRIORITY_EN
                m_ptr = q[0];
`endif
                q.delete(0);
                m_cnt++;
            end
        end else if (iv && v != 4'd0) begin
`ifdef ENC_RR_PRIORITY_EN
            for (int k = 1; k <= 4; k++) if (v[(m_ptr + k) % 4]) q.push_back((m_ptr + k) % 4);
`else
            for (int k = 0; k < 4; k++) if (v[k]) q.push_back(k);
`endif
        end
        m_zero = z;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input bit ir, input bit ov, input int code,
                              input bit last, input bit zp, input int cnt);
        check({tag, ".in_ready"}, int'(in_ready), int'(ir));
        check({tag, ".out_valid"}, int'(out_valid), int'(ov));
        check({tag, ".out_code"}, int'(out_code), code);
        check({tag, ".out_last"}, int'(out_last), int'(last));
        check({tag, ".zero_pulse"}, int'(zero_pulse), int'(zp));
        check({tag, ".evt_cnt"}, int'(evt_cnt), cnt);
    endtask

    task automatic apply(input bit r, input bit iv, input logic [3:0] v, input bit ordy);
        rst       = r;
        in_valid  = iv;
        in_vec    = v;
        out_ready = ordy;
        @(posedge clk);
        model_step(r, iv, v, ordy);
        #1;
    endtask

    typedef struct {
        bit         r;
        bit         iv;
        logic [3:0] vec;
        bit         ordy;
        bit         e_ir;
        bit         e_ov;
        int         e_code;
        bit         e_last;
        bit         e_zp;
        int         e_cnt;
    } vec_t;

    function automatic vec_t mk(input bit r, input bit iv, input logic [3:0] v, input bit ordy,
                                input bit ir, input bit ov, input int code, input bit last,
                                input bit zp, input int cnt);
        vec_t t;
        t.r = r; t.iv = iv; t.vec = v; t.ordy = ordy;
        t.e_ir = ir; t.e_ov = ov; t.e_code = code; t.e_last = last; t.e_zp = zp; t.e_cnt = cnt;
        return t;
    endfunction

    vec_t tbl[14];
    int   wrap_seq[5];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_vec = 4'd0; out_ready = 1'b0;

        // reset, 1010 stream, zero vector, 1111 under backpressure (ignored input during EMIT)
        tbl[0]  = mk(1, 0, 4'b0000, 0,  1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 4'b1010, 1,  0, 1, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 4'b0000, 1,  0, 1, 3, 1, 0, 1);
        tbl[3]  = mk(0, 0, 4'b0000, 1,  1, 0, 0, 0, 0, 2);
        tbl[4]  = mk(0, 1, 4'b0000, 0,  1, 0, 0, 0, 1, 2);
        tbl[5]  = mk(0, 0, 4'b0000, 0,  1, 0, 0, 0, 0, 2);
        tbl[6]  = mk(0, 1, 4'b1111, 0,  0, 1, 0, 0, 0, 2);
        tbl[7]  = mk(0, 1, 4'b0010, 0,  0, 1, 0, 0, 0, 2);
        tbl[8]  = mk(0, 0, 4'b0000, 0,  0, 1, 0, 0, 0, 2);
        tbl[9]  = mk(0, 0, 4'b0000, 0,  0, 1, 0, 0, 0, 2);
        tbl[10] = mk(0, 1, 4'b0001, 1,  0, 1, 1, 0, 0, 3);
        tbl[11] = mk(0, 0, 4'b0000, 1,  0, 1, 2, 0, 0, 4);
        tbl[12] = mk(0, 0, 4'b0000, 1,  0, 1, 3, 1, 0, 5);
        tbl[13] = mk(0, 0, 4'b0000, 1,  1, 0, 0, 0, 0, 6);

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].r, tbl[i].iv, tbl[i].vec, tbl[i].ordy);
            check_outs($sformatf("tbl%0d", i), tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_code,
                       tbl[i].e_last, tbl[i].e_zp, tbl[i].e_cnt);
        end

        // reset in the middle of 1111 discards remaining bits
        apply(1, 0, 4'b0000, 0);
        apply(0, 1, 4'b1111, 0);
        check_outs("rst_mid.accept", 0, 1, 0, 0, 0, 0);
        apply(0, 0, 4'b0000, 1);
        check_outs("rst_mid.first", 0, 1, 1, 0, 0, 1);
        apply(1, 1, 4'b0110, 1);
        check_outs("rst_mid.reset", 1, 0, 0, 0, 0, 0);
        check("rst_mid.cnt2", int'(d2_evt_cnt), 0);
        apply(0, 1, 4'b0100, 0);
        check_outs("rst_mid.next", 0, 1, 2, 1, 0, 0);
        apply(0, 0, 4'b0000, 1);
        check_outs("rst_mid.done", 1, 0, 0, 0, 0, 1);

        // narrow counter wraps
        wrap_seq[0] = 1; wrap_seq[1] = 2; wrap_seq[2] = 3; wrap_seq[3] = 0; wrap_seq[4] = 1;
        apply(1, 0, 4'b0000, 0);
        for (int n = 0; n < 5; n++) begin
            apply(0, 1, 4'b0001, 0);
            check_outs($sformatf("wrap%0d.emit", n), 0, 1, 0, 1, 0, n);
            apply(0, 0, 4'b0000, 1);
            check($sformatf("wrap%0d.cnt2", n), int'(d2_evt_cnt), wrap_seq[n]);
        end

        // selection order across vectors
        apply(1, 0, 4'b0000, 0);
        apply(0, 1, 4'b0010, 1);
        check_outs("order.a", 0, 1, 1, 1, 0, 0);
        apply(0, 0, 4'b0000, 1);
        check_outs("order.a_done", 1, 0, 0, 0, 0, 1);
        apply(0, 1, 4'b0101, 1);
`ifdef ENC_RR_PRIORITY_EN
        check_outs("order.b0", 0, 1, 2, 0, 0, 1);
        apply(0, 0, 4'b0000, 1);
        check_outs("order.b1", 0, 1, 0, 1, 0, 2);
`else
        check_outs("order.b0", 0, 1, 0, 0, 0, 1);
        apply(0, 0, 4'b0000, 1);
        check_outs("order.b1", 0, 1, 2, 1, 0, 2);
`endif
        apply(0, 0, 4'b0000, 1);
        check_outs("order.b_done", 1, 0, 0, 0, 0, 3);

        // randomized traffic against the queue model
        apply(1, 0, 4'b0000, 0);
        for (int c = 0; c < 3000; c++) begin
            bit         r, iv, ordy;
            logic [3:0] v;
            r    = ($urandom_range(199) == 0);
            iv   = ($urandom_range(2) != 0);
            v    = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom_range(15));
            ordy = ($urandom_range(9) < 7);
            apply(r, iv, v, ordy);
            check_outs("rnd", q.size() == 0, q.size() != 0, (q.size() != 0) ? q[0] : 0,
                       q.size() == 1, m_zero, m_cnt % 256);
            check("rnd.cnt2", int'(d2_evt_cnt), m_cnt % 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
